// File: rtl/uart_router_pkg.sv
// Shared types for the UART channel router.
// Holds the default channel-index width and the arbiter state encoding.
package uart_router_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CH_W = $clog2(NUM_CH_DEF);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } arb_state_t;

endpackage

// File: rtl/uart_chan_router_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after rr_ptr.
// Ports: req, rr_ptr in; gnt_idx (winner), any_req out.
module rr_arbiter
    import uart_router_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] rr_ptr,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx,
    output logic                      any_req
);

    localparam int CW = $clog2(NUM_CH);

    logic found;

    assign any_req = |req;

    // Search rr_ptr+1 .. rr_ptr+NUM_CH; the last candidate is rr_ptr itself.
    always_comb begin
        gnt_idx = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % NUM_CH]) begin
                found = 1'b1;
                gnt_idx = CW'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/uart_chan_router.sv
// Steers buttons/RX bytes to the active mode's channel and arbitrates
// the shared UART TX among NUM_CH packet sources (round-robin, packet lock).
// Ports: clk, reset; mode_sel, btn_in -> btn_out; rx_* routing;
// s_valid/s_data/s_last/s_ready sources; m_valid/m_data/m_ready sink;
// grant, busy, timeout_pulse status.
module uart_chan_router
    import uart_router_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_BTN     = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NUM_CH)-1:0]   mode_sel,
    input  logic [NUM_BTN-1:0]          btn_in,
    output logic [NUM_CH*NUM_BTN-1:0]   btn_out,
    input  logic                        rx_done_in,
    input  logic [DATA_W-1:0]           rx_data_in,
    output logic [NUM_CH-1:0]           rx_done_out,
    output logic [DATA_W-1:0]           rx_data_out,
    input  logic [NUM_CH-1:0]           s_valid,
    input  logic [NUM_CH*DATA_W-1:0]    s_data,
    input  logic [NUM_CH-1:0]           s_last,
    output logic [NUM_CH-1:0]           s_ready,
    output logic                        m_valid,
    output logic [DATA_W-1:0]           m_data,
    input  logic                        m_ready,
    output logic [$clog2(NUM_CH)-1:0]   grant,
    output logic                        busy,
    output logic                        timeout_pulse
);

    localparam int CW = $clog2(NUM_CH);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic [TW-1:0] STALL_MAX = TW'(TIMEOUT_CYC - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] grant_q, grant_d;
    logic [CW-1:0] rr_q, rr_d;
    logic [CW-1:0] arb_idx;
    logic [CW-1:0] mode_act, mode_nxt;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          any_req, lock, cur_valid;
    logic          xfer, stall_hit, mode_chg;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (s_valid),
        .rr_ptr  (rr_q),
        .gnt_idx (arb_idx),
        .any_req (any_req)
    );

    // Gating with reset keeps a byte from being accepted
    // in the cycle the frame is abandoned.
    assign lock      = (state_q == ST_LOCK) && !reset;
    assign cur_valid = s_valid[grant_q];
    assign xfer      = lock && cur_valid && m_ready;
    assign stall_hit = lock && !cur_valid && (cnt_q == STALL_MAX);

    assign m_valid       = lock && cur_valid;
    assign m_data        = lock ? s_data[grant_q*DATA_W +: DATA_W] : '0;
    assign grant         = grant_q;
    assign busy          = (state_q == ST_LOCK);
    assign timeout_pulse = stall_hit;

    always_comb begin
        s_ready = '0;
        if (lock) begin
            s_ready[grant_q] = m_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (any_req) begin
                    state_d = ST_LOCK;
                    grant_d = arb_idx;
                end
            end
            ST_LOCK: begin
                if ((xfer && s_last[grant_q]) || stall_hit) begin
                    state_d = ST_IDLE;
                    rr_d    = grant_q;
                    cnt_d   = '0;
                end else if (cur_valid) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
        endcase
    end

    // Out-of-range selections keep the previous mode.
    assign mode_nxt = (int'(mode_sel) < NUM_CH) ? mode_sel : mode_act;
    assign mode_chg = (mode_nxt != mode_act);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_q        <= LAST_CH;
            cnt_q       <= '0;
            mode_act    <= '0;
            btn_out     <= '0;
            rx_done_out <= '0;
            rx_data_out <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mode_act    <= mode_nxt;
            btn_out     <= '0;
            rx_done_out <= '0;
            // Mode switch cycle routes nothing, so no channel
            // sees a stray pulse meant for the other owner.
            if (!mode_chg) begin
                btn_out[mode_act*NUM_BTN +: NUM_BTN] <= btn_in;
                rx_done_out[mode_act] <= rx_done_in;
            end
            if (rx_done_in) begin
                rx_data_out <= rx_data_in;
            end
        end
    end

endmodule

// File: tb/tb_uart_chan_router.sv
// Directed bench for uart_chan_router: arbitration order, packet lock,
// stall timeout, mode/button/RX routing and mid-packet reset.
`define CHK(t, o, e) chk(t, 32'(o), 32'(e))

module tb_uart_chan_router;

    logic        clk;
    logic        reset;
    logic [1:0]  mode_sel;
    logic [3:0]  btn_in;
    logic [15:0] btn_out;
    logic        rx_done_in;
    logic [7:0]  rx_data_in;
    logic [3:0]  rx_done_out;
    logic [7:0]  rx_data_out;
    logic [3:0]  s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_last;
    logic [3:0]  s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_pulse;

    logic [11:0] btn3;
    logic [2:0]  rxd3;
    logic [7:0]  rxb3;
    logic [2:0]  srdy3;
    logic        mv3;
    logic [7:0]  md3;
    logic [1:0]  g3;
    logic        b3;
    logic        to3;

    int checks = 0;
    int errors = 0;
    int ord[5] = '{0, 1, 2, 3, 0};
    int b;
    logic seen;

    uart_chan_router #(
        .NUM_CH(4), .DATA_W(8), .NUM_BTN(4), .TIMEOUT_CYC(16)
    ) u_dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel),
        .btn_in(btn_in), .btn_out(btn_out),
        .rx_done_in(rx_done_in), .rx_data_in(rx_data_in),
        .rx_done_out(rx_done_out), .rx_data_out(rx_data_out),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .grant(grant), .busy(busy),
        .timeout_pulse(timeout_pulse)
    );

    uart_chan_router #(
        .NUM_CH(3), .DATA_W(8), .NUM_BTN(4)
    ) u_dut3 (
        .clk(clk), .reset(reset), .mode_sel(mode_sel),
        .btn_in(btn_in), .btn_out(btn3),
        .rx_done_in(1'b0), .rx_data_in(8'h00),
        .rx_done_out(rxd3), .rx_data_out(rxb3),
        .s_valid(3'b000), .s_data(24'h0), .s_last(3'b000),
        .s_ready(srdy3), .m_valid(mv3), .m_data(md3),
        .m_ready(1'b0), .grant(g3), .busy(b3),
        .timeout_pulse(to3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mode_sel = 2'd0;
        btn_in = 4'h0;
        rx_done_in = 1'b0;
        rx_data_in = 8'h00;
        s_valid = 4'h0;
        s_data = 32'h0;
        s_last = 4'h0;
        m_ready = 1'b0;
        tick();
        tick();
        probe();
        `CHK("rst_busy", busy, 1'b0);
        `CHK("rst_grant", grant, 2'd0);
        `CHK("rst_mvalid", m_valid, 1'b0);
        `CHK("rst_sready", s_ready, 4'h0);
        `CHK("rst_btn", btn_out, 16'h0);
        `CHK("rst_rxdone", rx_done_out, 4'h0);
        `CHK("rst_rxdata", rx_data_out, 8'h0);
        `CHK("rst_to", timeout_pulse, 1'b0);
        tick();

        reset = 1'b0;
        s_valid = 4'hF;
        s_last = 4'hF;
        m_ready = 1'b1;
        s_data = 32'hA3A2A1A0;
        for (int i = 0; i < 5; i++) begin
            probe();
            `CHK("t1_idle", busy, 1'b0);
            `CHK("t1_idle_mv", m_valid, 1'b0);
            tick();
            probe();
            checks++;
            if (grant !== 2'(ord[i])) begin
                errors++;
                $error("FAIL t1_grant observed=%0d expected=%0d",
                       grant, ord[i]);
            end
            `CHK("t1_busy", busy, 1'b1);
            `CHK("t1_data", m_data, 8'hA0 + ord[i]);
            `CHK("t1_rdy", s_ready, 1 << ord[i]);
            tick();
        end
        s_valid = 4'h0;
        s_last = 4'h0;

        s_valid = 4'b0100;
        s_data = 32'h0;
        s_data[16 +: 8] = 8'h41;
        probe();
        `CHK("t2_idle", busy, 1'b0);
        tick();
        b = 0;
        for (int c = 1; c <= 20 && b < 5; c++) begin
            m_ready = (c % 2 == 1);
            s_data[16 +: 8] = 8'(8'h41 + b);
            s_last[2] = (b == 4);
            if (c >= 2) begin
                s_valid[1] = 1'b1;
                s_data[8 +: 8] = 8'h99;
                s_last[1] = 1'b1;
            end
            probe();
            `CHK("t2_grant", grant, 2'd2);
            checks++;
            if (m_data !== 8'(8'h41 + b)) begin
                errors++;
                $error("FAIL t2_data observed=%0h expected=%0h",
                       m_data, 8'(8'h41 + b));
            end
            `CHK("t2_rdy", s_ready, m_ready ? 4'b0100 : 4'b0000);
            if (m_ready) b++;
            tick();
        end
        `CHK("t2_bytes", b, 5);
        s_valid = 4'b0010;
        s_last = 4'b0010;
        m_ready = 1'b1;
        probe();
        `CHK("t2_gap", busy, 1'b0);
        `CHK("t2_gap_mv", m_valid, 1'b0);
        tick();
        probe();
        `CHK("t2_ch1", grant, 2'd1);
        `CHK("t2_ch1_data", m_data, 8'h99);
        tick();
        s_valid = 4'h0;
        s_last = 4'h0;

        s_valid = 4'b1000;
        s_data[24 +: 8] = 8'h77;
        probe();
        `CHK("t3_idle", busy, 1'b0);
        tick();
        probe();
        `CHK("t3_grant", grant, 2'd3);
        `CHK("t3_data", m_data, 8'h77);
        `CHK("t3_rdy", s_ready, 4'b1000);
        tick();
        s_valid = 4'h0;
        for (int j = 1; j <= 16; j++) begin
            probe();
            checks++;
            if (timeout_pulse !== (j == 16)) begin
                errors++;
                $error("FAIL t3_to observed=%0b expected=%0b",
                       timeout_pulse, (j == 16));
            end
            `CHK("t3_busy", busy, 1'b1);
            tick();
        end
        probe();
        `CHK("t3_after", busy, 1'b0);
        `CHK("t3_after_to", timeout_pulse, 1'b0);
        tick();
        s_valid = 4'b1000;
        m_ready = 1'b0;
        probe();
        tick();
        seen = 1'b0;
        for (int j = 0; j < 100; j++) begin
            probe();
            seen = seen | timeout_pulse;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $error("FAIL t3_sink_stall observed=%0b expected=0", seen);
        end
        probe();
        `CHK("t3_hold", busy, 1'b1);
        `CHK("t3_hold_g", grant, 2'd3);
        tick();
        m_ready = 1'b1;
        s_last = 4'b1000;
        probe();
        `CHK("t3_end_rdy", s_ready, 4'b1000);
        tick();
        s_valid = 4'h0;
        s_last = 4'h0;

        btn_in = 4'b0100;
        tick();
        probe();
        `CHK("t4_m0", btn_out, 16'h0004);
        `CHK("t4_m0_3ch", btn3, 12'h004);
        tick();
        mode_sel = 2'd2;
        tick();
        probe();
        `CHK("t4_guard", btn_out, 16'h0000);
        `CHK("t4_guard_3ch", btn3, 12'h000);
        tick();
        probe();
        `CHK("t4_m2", btn_out, 16'h0400);
        `CHK("t4_m2_3ch", btn3, 12'h400);
        mode_sel = 2'd3;
        tick();
        probe();
        `CHK("t4_m3_guard", btn_out, 16'h0000);
        `CHK("t4_oor_hold", btn3, 12'h400);
        tick();
        probe();
        `CHK("t4_m3", btn_out, 16'h4000);
        `CHK("t4_oor_hold2", btn3, 12'h400);

        mode_sel = 2'd1;
        s_valid = 4'b0001;
        s_data[0 +: 8] = 8'h01;
        s_last = 4'h0;
        m_ready = 1'b0;
        tick();
        tick();
        rx_done_in = 1'b1;
        rx_data_in = 8'h5A;
        probe();
        `CHK("t5_lock", busy, 1'b1);
        `CHK("t5_grant", grant, 2'd0);
        `CHK("t5_rdy", s_ready, 4'h0);
        tick();
        rx_done_in = 1'b0;
        rx_data_in = 8'h00;
        probe();
        `CHK("t5_done", rx_done_out, 4'b0010);
        `CHK("t5_data", rx_data_out, 8'h5A);
        `CHK("t5_busy", busy, 1'b1);
        tick();
        probe();
        `CHK("t5_pulse", rx_done_out, 4'b0000);
        `CHK("t5_keep", rx_data_out, 8'h5A);

        m_ready = 1'b1;
        tick();
        s_data[0 +: 8] = 8'h02;
        tick();
        s_data[0 +: 8] = 8'h03;
        reset = 1'b1;
        probe();
        `CHK("t6_rst_mv", m_valid, 1'b0);
        `CHK("t6_rst_rdy", s_ready, 4'h0);
        tick();
        reset = 1'b0;
        s_valid = 4'hF;
        s_last = 4'hF;
        probe();
        `CHK("t6_idle", busy, 1'b0);
        `CHK("t6_mv", m_valid, 1'b0);
        `CHK("t6_rdy", s_ready, 4'h0);
        `CHK("t6_grant", grant, 2'd0);
        `CHK("t6_rxd", rx_data_out, 8'h00);
        tick();
        probe();
        `CHK("t6_rearb", grant, 2'd0);
        `CHK("t6_rebusy", busy, 1'b1);
        `CHK("t6_redata", m_data, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
